// File: rtl/bsg_manycore_pkg.sv
// bsg_manycore_pkg: shared host-arbiter state type and width helper
package bsg_manycore_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, DRAINED} bsg_host_arb_state_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_manycore_host_rr_arb.sv
// bsg_manycore_host_rr_arb: round-robin pick starting at ptr_i, grant gated by yumi_i
module bsg_manycore_host_rr_arb
    import bsg_manycore_pkg::*;
#(
    parameter  int num_req_p   = 4,
    localparam int id_width_lp = safe_clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]   v_i,
    input  logic                   yumi_i,
    input  logic [id_width_lp-1:0] ptr_i,
    output logic [num_req_p-1:0]   grant_o,
    output logic [id_width_lp-1:0] grant_id_o,
    output logic [id_width_lp-1:0] ptr_n_o
);

    logic [id_width_lp-1:0] win;
    logic                   take;
    int                     k;

    assign take       = yumi_i && |v_i;
    assign grant_id_o = win;
    assign ptr_n_o    = !take ? ptr_i : (win == id_width_lp'(num_req_p - 1)) ? '0 : id_width_lp'(int'(win) + 1);

    // Scan from the farthest offset back so the nearest valid index to ptr_i wins
    always_comb begin
        win     = ptr_i;
        k       = 0;
        grant_o = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            k = (int'(ptr_i) + i) % num_req_p;
            if (v_i[k]) win = id_width_lp'(k);
        end
        if (take) grant_o[win] = 1'b1;
    end

endmodule

// File: rtl/bsg_manycore_host_arbiter.sv
// bsg_manycore_host_arbiter: credit-limited round-robin host link arbiter with drain; BSG_MANYCORE_HOST_ARB_PERF_EN adds grant counters
module bsg_manycore_host_arbiter
    import bsg_manycore_pkg::*;
#(
    parameter  int num_req_p         = 4,
    parameter  int pkt_width_p       = 128,
    parameter  int max_out_credits_p = 16,
    localparam int id_width_lp       = safe_clog2(num_req_p),
    localparam int credit_width_lp   = safe_clog2(max_out_credits_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*pkt_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]             req_ready_o,
    output logic                             link_v_o,
    output logic [pkt_width_p-1:0]           link_data_o,
    output logic [id_width_lp-1:0]           link_id_o,
    input  logic                             link_ready_i,
    input  logic                             rsp_v_i,
    input  logic [id_width_lp-1:0]           rsp_id_i,
    output logic [num_req_p-1:0]             rsp_v_o,
    input  logic                             drain_i,
    output logic                             drained_o,
`ifdef BSG_MANYCORE_HOST_ARB_PERF_EN
    output logic [num_req_p*32-1:0]          grant_count_o,
`endif
    output logic [credit_width_lp-1:0]       credits_o
);

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    bsg_host_arb_state_e          state_r, state_n;
    logic [id_width_lp-1:0]       ptr_r, ptr_n, grant_id;
    logic [num_req_p-1:0]         grant;
    logic [credit_width_lp-1:0]   credits_n;
    logic                         grant_en, granted, link_v_n, rsp_take;

    assign grant_en    = reset_n_i && state_r == IDLE && !drain_i && credits_o != '0 && (!link_v_o || link_ready_i);
    assign granted     = |grant;
    assign req_ready_o = grant;
    assign link_v_n    = granted || (link_v_o && !link_ready_i);
    assign rsp_take    = rsp_v_i && credits_o != max_credits_lp;
    assign credits_n   = credits_o + credit_width_lp'(rsp_take) - credit_width_lp'(granted);
    assign rsp_v_o     = (reset_n_i && rsp_v_i) ? num_req_p'(1) << rsp_id_i : '0;
    assign drained_o   = state_r == DRAINED;

    bsg_manycore_host_rr_arb #(.num_req_p(num_req_p)) rr_arb (
        .v_i       (req_v_i),
        .yumi_i    (grant_en),
        .ptr_i     (ptr_r),
        .grant_o   (grant),
        .grant_id_o(grant_id),
        .ptr_n_o   (ptr_n)
    );

    // Drain completes on the same edge that the last credit returns and the register empties
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    state_n = drain_i ? DRAIN : IDLE;
            DRAIN:   state_n = !drain_i ? IDLE : (!link_v_n && credits_n == max_credits_lp) ? DRAINED : DRAIN;
            DRAINED: state_n = drain_i ? DRAINED : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control state: FSM, round-robin pointer and credit counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            credits_o <= max_credits_lp;
        end else begin
            state_r   <= state_n;
            ptr_r     <= ptr_n;
            credits_o <= credits_n;
        end
    end

    // Output register loads the granted packet and holds it until the link accepts it
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            link_v_o    <= 1'b0;
            link_data_o <= '0;
            link_id_o   <= '0;
        end else begin
            link_v_o <= link_v_n;
            if (granted) begin
                link_data_o <= req_data_i[int'(grant_id)*pkt_width_p +: pkt_width_p];
                link_id_o   <= grant_id;
            end
        end
    end

`ifdef BSG_MANYCORE_HOST_ARB_PERF_EN
    // Per-requester grant counters that stick at all-ones
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) grant_count_o <= '0;
        else
            for (int i = 0; i < num_req_p; i++)
                if (grant[i] && grant_count_o[i*32 +: 32] != '1)
                    grant_count_o[i*32 +: 32] <= grant_count_o[i*32 +: 32] + 32'd1;
    end
`endif

    rsp_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(rsp_v_i && credits_o == max_credits_lp));

endmodule

// File: tb/tb_bsg_manycore_host_arbiter.sv
// tb_bsg_manycore_host_arbiter: directed and randomized checks of the host link arbiter
module tb_bsg_manycore_host_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int M  = 16;
    localparam int M2 = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_v, req_ready, rsp_vo;
    logic [N*W-1:0] req_data;
    logic           link_v, link_ready, rsp_v, drain, drained;
    logic [W-1:0]   link_data;
    logic [1:0]     link_id, rsp_id;
    logic [4:0]     credits;

    logic [N-1:0]   req_v2, req_ready2, rsp_vo2;
    logic [N*W-1:0] req_data2;
    logic           link_v2, link_ready2, rsp_v2, drain2, drained2;
    logic [W-1:0]   link_data2;
    logic [1:0]     link_id2, rsp_id2;
    logic [1:0]     credits2;

`ifdef BSG_MANYCORE_HOST_ARB_PERF_EN
    logic [N*32-1:0] gc1, gc2;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] d [N];

    bsg_manycore_host_arbiter #(.num_req_p(N), .pkt_width_p(W), .max_out_credits_p(M)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_data_i(req_data), .req_ready_o(req_ready),
        .link_v_o(link_v), .link_data_o(link_data), .link_id_o(link_id), .link_ready_i(link_ready),
        .rsp_v_i(rsp_v), .rsp_id_i(rsp_id), .rsp_v_o(rsp_vo), .drain_i(drain), .drained_o(drained),
`ifdef BSG_MANYCORE_HOST_ARB_PERF_EN
        .grant_count_o(gc1),
`endif
        .credits_o(credits));

    bsg_manycore_host_arbiter #(.num_req_p(N), .pkt_width_p(W), .max_out_credits_p(M2)) dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v2), .req_data_i(req_data2), .req_ready_o(req_ready2),
        .link_v_o(link_v2), .link_data_o(link_data2), .link_id_o(link_id2), .link_ready_i(link_ready2),
        .rsp_v_i(rsp_v2), .rsp_id_i(rsp_id2), .rsp_v_o(rsp_vo2), .drain_i(drain2), .drained_o(drained2),
`ifdef BSG_MANYCORE_HOST_ARB_PERF_EN
        .grant_count_o(gc2),
`endif
        .credits_o(credits2));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data();
        for (int i = 0; i < N; i++) begin
            d[i] = W'($urandom);
            req_data[i*W +: W] = d[i];
            req_data2[i*W +: W] = d[i];
        end
    endtask

    task automatic do_reset();
        req_v = '0; link_ready = 1'b0; rsp_v = 1'b0; rsp_id = '0; drain = 1'b0;
        req_v2 = '0; link_ready2 = 1'b0; rsp_v2 = 1'b0; rsp_id2 = '0; drain2 = 1'b0;
        load_data();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        req_v = '1; rsp_v = 1'b1; rsp_id = 2'd2;
        #3;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if (link_v !== 1'b0) begin errors++; $display("FAIL reset_link_v got %b exp 0", link_v); end
        checks++; if (credits !== 5'd16) begin errors++; $display("FAIL reset_credits got %0d exp 16", credits); end
        checks++; if (credits2 !== 2'd2) begin errors++; $display("FAIL reset_credits2 got %0d exp 2", credits2); end
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained got %b exp 0", drained); end
        checks++; if (rsp_vo !== 4'b0) begin errors++; $display("FAIL reset_rsp_v_o got %b exp 0000", rsp_vo); end
        checks++; if (link_data !== '0 || link_id !== '0) begin errors++; $display("FAIL reset_link_data got %h/%0d exp 0/0", link_data, link_id); end
        do_reset();
    endtask

    task automatic test_round_robin();
        do_reset();
        req_v = '1; link_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << (k % N))) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, 4'(1 << (k % N))); end
            cyc();
            checks++; if (link_v !== 1'b1 || link_id !== 2'(k % N) || link_data !== d[k % N])
                begin errors++; $display("FAIL rr_link%0d got v%b id%0d %h exp v1 id%0d %h", k, link_v, link_id, link_data, k % N, d[k % N]); end
        end
        req_v = '0;
        checks++; if (credits !== 5'd11) begin errors++; $display("FAIL rr_credits got %0d exp 11", credits); end
        cyc();
        checks++; if (link_v !== 1'b0) begin errors++; $display("FAIL rr_empty got %b exp 0", link_v); end
    endtask

    task automatic test_credit_limit();
        int cnt;
        do_reset();
        req_v2 = '1; link_ready2 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            #1 cnt += int'(|req_ready2);
            cyc();
        end
        checks++; if (cnt !== 2) begin errors++; $display("FAIL credit_limit_grants got %0d exp 2", cnt); end
        checks++; if (req_ready2 !== 4'b0 || credits2 !== 2'd0) begin errors++; $display("FAIL credit_limit_idle got %b/%0d exp 0000/0", req_ready2, credits2); end
        rsp_v2 = 1'b1; rsp_id2 = 2'd0;
        cnt = 0;
        #1 cnt += int'(|req_ready2);
        cyc();
        rsp_v2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 cnt += int'(|req_ready2);
            cyc();
        end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL credit_return_grants got %0d exp 1", cnt); end
        checks++; if (link_id2 !== 2'd2) begin errors++; $display("FAIL credit_return_id got %0d exp 2", link_id2); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        do_reset();
        req_v = 4'b0100;
        held = d[2];
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first got %b exp 0100", req_ready); end
        cyc();
        req_v = '1;
        load_data();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_ready%0d got %b exp 0000", k, req_ready); end
            checks++; if (link_v !== 1'b1 || link_data !== held) begin errors++; $display("FAIL bp_hold%0d got v%b %h exp v1 %h", k, link_v, link_data, held); end
            cyc();
        end
        link_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_resume got %b exp 1000", req_ready); end
        cyc();
        checks++; if (link_id !== 2'd3 || link_data !== d[3]) begin errors++; $display("FAIL bp_next got id%0d %h exp id3 %h", link_id, link_data, d[3]); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_v2 = 4'b0001; link_ready2 = 1'b1;
        cyc();
        checks++; if (credits2 !== 2'd1) begin errors++; $display("FAIL sim_setup got %0d exp 1", credits2); end
        req_v2 = 4'b0010; rsp_v2 = 1'b1; rsp_id2 = 2'd2;
        #1;
        checks++; if (req_ready2 !== 4'b0010) begin errors++; $display("FAIL sim_grant got %b exp 0010", req_ready2); end
        checks++; if (rsp_vo2 !== 4'b0100) begin errors++; $display("FAIL sim_rsp_v_o got %b exp 0100", rsp_vo2); end
        cyc();
        req_v2 = '0; rsp_v2 = 1'b0;
        checks++; if (credits2 !== 2'd1) begin errors++; $display("FAIL sim_credits got %0d exp 1", credits2); end
        #1;
        checks++; if (rsp_vo2 !== 4'b0) begin errors++; $display("FAIL sim_rsp_off got %b exp 0000", rsp_vo2); end
    endtask

    task automatic test_drain();
        do_reset();
        req_v = '1; link_ready = 1'b1;
        repeat (3) cyc();
        checks++; if (credits !== 5'd13) begin errors++; $display("FAIL drain_setup got %0d exp 13", credits); end
        drain = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL drain_nogrant got %b exp 0000", req_ready); end
        cyc();
        checks++; if (link_v !== 1'b0) begin errors++; $display("FAIL drain_flush got %b exp 0", link_v); end
        cyc();
        checks++; if (drained !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL drain_wait got %b/%b exp 0/0000", drained, req_ready); end
        for (int r = 0; r < 3; r++) begin
            rsp_v = 1'b1; rsp_id = 2'(r);
            #1;
            checks++; if (rsp_vo !== 4'(1 << r)) begin errors++; $display("FAIL drain_rsp%0d got %b exp %b", r, rsp_vo, 4'(1 << r)); end
            cyc();
            if (r < 2) begin
                checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_early%0d got %b exp 0", r, drained); end
            end
        end
        rsp_v = 1'b0;
        checks++; if (drained !== 1'b1 || credits !== 5'd16) begin errors++; $display("FAIL drain_done got %b/%0d exp 1/16", drained, credits); end
        drain = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL drain_exit_wait got %b exp 0000", req_ready); end
        cyc();
        checks++; if (req_ready !== 4'b1000 || drained !== 1'b0) begin errors++; $display("FAIL drain_resume got %b/%b exp 1000/0", req_ready, drained); end
        req_v = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_v = 4'b0001;
        cyc();
        checks++; if (link_v !== 1'b1 || credits !== 5'd15) begin errors++; $display("FAIL mid_setup got %b/%0d exp 1/15", link_v, credits); end
        req_v = '0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (link_v !== 1'b0 || link_data !== '0) begin errors++; $display("FAIL mid_async got v%b %h exp v0 0", link_v, link_data); end
        #1 reset_n = 1'b1;
        cyc();
        checks++; if (credits !== 5'd16 || link_v !== 1'b0) begin errors++; $display("FAIL mid_after got %0d/%b exp 16/0", credits, link_v); end
    endtask

    task automatic test_random();
        int m_cr, m_last, g;
        logic m_lv;
        logic [W-1:0] m_ld;
        logic [1:0] m_lid;
        logic [N-1:0] exp_rdy, exp_rsp;
        do_reset();
        m_cr = M; m_last = N - 1; m_lv = 1'b0; m_ld = '0; m_lid = '0;
        for (int c = 0; c < 400; c++) begin
            checks++; if (link_v !== m_lv || credits !== 5'(m_cr)) begin errors++; $display("FAIL rand_state c%0d got v%b cr%0d exp v%b cr%0d", c, link_v, credits, m_lv, m_cr); end
            if (m_lv) begin
                checks++; if (link_data !== m_ld || link_id !== m_lid) begin errors++; $display("FAIL rand_link c%0d got %h/%0d exp %h/%0d", c, link_data, link_id, m_ld, m_lid); end
            end
            req_v = N'($urandom);
            load_data();
            link_ready = ($urandom_range(0, 3) != 0);
            rsp_v = (m_cr < M) && ($urandom_range(0, 2) == 0);
            rsp_id = 2'($urandom);
            g = -1;
            if (m_cr > 0 && (!m_lv || link_ready))
                for (int k = 1; k <= N; k++)
                    if (g < 0 && req_v[(m_last + k) % N]) g = (m_last + k) % N;
            exp_rdy = (g < 0) ? '0 : 4'(1 << g);
            exp_rsp = rsp_v ? 4'(1 << rsp_id) : '0;
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, req_ready, exp_rdy); end
            checks++; if (rsp_vo !== exp_rsp) begin errors++; $display("FAIL rand_rsp c%0d got %b exp %b", c, rsp_vo, exp_rsp); end
            if (g >= 0) begin
                m_lv = 1'b1; m_ld = d[g]; m_lid = 2'(g); m_last = g; m_cr--;
            end else if (link_ready) m_lv = 1'b0;
            if (rsp_v) m_cr++;
            cyc();
        end
        req_v = '0; rsp_v = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_backpressure();
        test_simultaneous();
        test_drain();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
